// File: rtl/apb_master_bridge.sv
// apb_master_bridge
// Single-outstanding APB master. Turns a valid/ready request stream into
// APB SETUP/ENABLE transfers and returns one pulsed response per request.
// The downstream slave registers its read data, so reads take an extra
// CAPTURE cycle with psel low before prdata is sampled.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transfer in flight, ready for a request
// SETUP   | APB setup phase (psel=1, penable=0)
// ENABLE  | APB access phase (psel=1, penable=1); writes complete here
// CAPTURE | bus released, slave's registered prdata is valid; read ends

module apb_master_bridge #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ENABLE  = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t state;
    logic   accept;

    // Ready is decoded from state and the in-flight transfer type; held low in reset.
    always_comb begin
        req_ready = 1'b0;
        if (!rst) begin
            unique case (state)
                IDLE:    req_ready = 1'b1;
                SETUP:   req_ready = 1'b0;
                ENABLE:  req_ready = pwrite;
                CAPTURE: req_ready = 1'b1;
                default: req_ready = 1'b0;
            endcase
        end
        accept = req_valid && req_ready;
    end

    // Transfer sequencing with registered APB, response and counter outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            wr_count  <= '0;
            rd_count  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        pwrite  <= req_write;
                        paddr   <= req_addr;
                        pwdata  <= req_wdata;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    psel    <= 1'b1;
                    penable <= 1'b1;
                    state   <= ENABLE;
                end
                ENABLE: begin
                    if (pwrite) begin
                        rsp_valid <= 1'b1;
                        rsp_write <= 1'b1;
                        rsp_rdata <= '0;
                        wr_count  <= wr_count + CNT_W'(1);
                        if (accept) begin
                            pwrite  <= req_write;
                            paddr   <= req_addr;
                            pwdata  <= req_wdata;
                            psel    <= 1'b1;
                            penable <= 1'b0;
                            state   <= SETUP;
                        end else begin
                            psel    <= 1'b0;
                            penable <= 1'b0;
                            state   <= IDLE;
                        end
                    end else begin
                        // Release the bus so the slave does not see a new transfer
                        // while its registered read data settles.
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        state   <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    rsp_valid <= 1'b1;
                    rsp_write <= 1'b0;
                    rsp_rdata <= prdata;
                    rd_count  <= rd_count + CNT_W'(1);
                    if (accept) begin
                        pwrite  <= req_write;
                        paddr   <= req_addr;
                        pwdata  <= req_wdata;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        state   <= SETUP;
                    end else begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
